// File: rtl/data_memory_pipe.sv
// data_memory_pipe: synchronous data RAM behind a valid/ready port, with a READ_LAT-deep
// read pipeline and a clear engine. Define DATA_MEM_PARITY_EN for per-word even parity.
module data_memory_pipe #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clear_req,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
`ifdef DATA_MEM_PARITY_EN
  input  logic              par_inject,
  output logic              rsp_perr,
`endif
  output logic              busy
);

  localparam int STAGES = READ_LAT - 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           clr_ptr;
  logic                        clr_en, clr_last;
  logic                        wr_acc, rd_acc, in_range, in_flight;
  logic [IDX_W-1:0]            req_idx;
  logic [DATA_W-1:0]           mem [DEPTH];
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0]             err_pipe;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;
`ifdef DATA_MEM_PARITY_EN
  logic                        par_mem [DEPTH];
  logic [STAGES:0]             perr_pipe;
`endif

  assign in_range  = 32'(req_addr) < 32'(DEPTH);
  assign req_idx   = req_addr[IDX_W-1:0];
  assign wr_acc    = req_valid && req_ready && req_write;
  assign rd_acc    = req_valid && req_ready && !req_write;
  assign in_flight = |vld_pipe;
  assign clr_last  = (clr_ptr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= (clr_en && !clr_last) ? clr_ptr + 1'b1 : '0;
    end
  end

  // req_ready drops in the same cycle as clear_req so nothing slips in on the switching edge
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    clr_en    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_en = 1'b1;
        if (clr_last) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b0;
        req_ready = !clear_req;
        if (clear_req) state_nxt = in_flight ? ST_DRAIN : ST_CLEAR;
      end
      ST_DRAIN: if (!in_flight) state_nxt = ST_CLEAR;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Storage is never reset; the clear engine is what zeroes it
  always_ff @(posedge sysclk) begin
    if (clr_en) begin
      mem[clr_ptr[IDX_W-1:0]] <= '0;
`ifdef DATA_MEM_PARITY_EN
      par_mem[clr_ptr[IDX_W-1:0]] <= 1'b0;
`endif
    end else if (wr_acc && in_range) begin
      mem[req_idx] <= req_wdata;
`ifdef DATA_MEM_PARITY_EN
      par_mem[req_idx] <= (^req_wdata) ^ par_inject;
`endif
    end
  end

  // Stage 0 samples the array at the accepting edge; empty slots carry zero data
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      err_pipe  <= '0;
      dat_pipe  <= '0;
`ifdef DATA_MEM_PARITY_EN
      perr_pipe <= '0;
`endif
    end else begin
      vld_pipe[0]  <= rd_acc;
      err_pipe[0]  <= rd_acc && !in_range;
      dat_pipe[0]  <= (rd_acc && in_range) ? mem[req_idx] : '0;
`ifdef DATA_MEM_PARITY_EN
      perr_pipe[0] <= rd_acc && in_range && (par_mem[req_idx] != ^mem[req_idx]);
`endif
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        err_pipe[i]  <= err_pipe[i-1];
        dat_pipe[i]  <= dat_pipe[i-1];
`ifdef DATA_MEM_PARITY_EN
        perr_pipe[i] <= perr_pipe[i-1];
`endif
      end
    end
  end

  assign rsp_valid = vld_pipe[STAGES];
  assign rsp_err   = err_pipe[STAGES];
  assign rsp_rdata = dat_pipe[STAGES];
`ifdef DATA_MEM_PARITY_EN
  assign rsp_perr  = perr_pipe[STAGES];
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe: u_a (DEPTH=256, READ_LAT=1) and u_b (DEPTH=200,
// READ_LAT=3) share the same stimulus and are checked against hand-computed values.
module tb_data_memory_pipe;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0, clear_req = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       a_ready, a_valid, a_err, a_busy;
  logic       b_ready, b_valid, b_err, b_busy;
  logic [7:0] a_rdata, b_rdata;
`ifdef DATA_MEM_PARITY_EN
  logic       par_inject = 1'b0;
  logic       a_perr, b_perr;
`endif
  int         checks = 0;
  int         errors = 0;

  always #5 sysclk = ~sysclk;

  data_memory_pipe u_a (
    .sysclk(sysclk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .clear_req(clear_req),
    .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_err(a_err),
`ifdef DATA_MEM_PARITY_EN
    .par_inject(par_inject), .rsp_perr(a_perr),
`endif
    .busy(a_busy)
  );

  data_memory_pipe #(.DEPTH(200), .READ_LAT(3)) u_b (
    .sysclk(sysclk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .clear_req(clear_req),
    .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_err(b_err),
`ifdef DATA_MEM_PARITY_EN
    .par_inject(par_inject), .rsp_perr(b_perr),
`endif
    .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ready", {a_ready, b_ready}, 2'b00);
    chk("rst_busy",  {a_busy, b_busy},   2'b11);
    chk("rst_valid", {a_valid, b_valid}, 2'b00);
    chk("rst_err",   {a_err, b_err},     2'b00);
    chk("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
`ifdef DATA_MEM_PARITY_EN
    chk("rst_perr",  {a_perr, b_perr},   2'b00);
`endif
  endtask

  // Called just after the rst_n-releasing edge; counts edges until req_ready rises
  task automatic wait_init(input int exp_a, input int exp_b);
    int na = 0;
    int nb = 0;
    for (int n = 1; n <= 400 && (na == 0 || nb == 0); n++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      if (n == exp_a - 1) chk("init_a_busy_pre", a_busy, 1'b1);
      if (na == 0 && a_ready) na = n;
      if (nb == 0 && b_ready) nb = n;
    end
    chk("init_a_edges", na, exp_a);
    chk("init_b_edges", nb, exp_b);
    chk("init_busy", {a_busy, b_busy}, 2'b00);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
    #1 chk("wr_ready", {a_ready, b_ready}, 2'b11);
    @(posedge sysclk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [7:0] ea, input logic erra,
                         input logic [7:0] eb, input logic errb);
    int la = 0, lb = 0, ca = 0, cb = 0;
    logic [7:0] da = '0, db = '0;
    logic ra = 1'b0, rb = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    #1 chk("rd_ready", {a_ready, b_ready}, 2'b11);
    @(posedge sysclk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge sysclk);
      if (a_valid) begin ca++; if (la == 0) la = k; da = a_rdata; ra = a_err; end
      if (b_valid) begin cb++; if (lb == 0) lb = k; db = b_rdata; rb = b_err; end
    end
    chk($sformatf("rd%02h_a_lat", addr), la, 1);
    chk($sformatf("rd%02h_a_cnt", addr), ca, 1);
    chk($sformatf("rd%02h_a_data", addr), da, ea);
    chk($sformatf("rd%02h_a_err", addr), ra, erra);
    chk($sformatf("rd%02h_b_lat", addr), lb, 3);
    chk($sformatf("rd%02h_b_cnt", addr), cb, 1);
    chk($sformatf("rd%02h_b_data", addr), db, eb);
    chk($sformatf("rd%02h_b_err", addr), rb, errb);
  endtask

`ifdef DATA_MEM_PARITY_EN
  task automatic par_read(input logic [7:0] addr, input logic exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    @(posedge sysclk); #1;
    req_valid = 1'b0;
    @(negedge sysclk);
    chk("par_a_valid", a_valid, 1'b1);
    chk("par_a_perr", a_perr, exp);
    repeat (2) @(negedge sysclk);
    chk("par_b_valid", b_valid, 1'b1);
    chk("par_b_perr", b_perr, exp);
  endtask
`endif

  initial begin
    logic [7:0] exp_d;
    int ba, bb, ra, rb, ga, gb;

    // Reset, then the clear engine runs DEPTH edges
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk_reset();
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    wait_init(256, 200);
    do_read(8'h10, 8'h00, 1'b0, 8'h00, 1'b0);

    // Back-to-back reads on u_a
    do_write(8'h00, 8'h55);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'(i);
      @(posedge sysclk); #1;
      @(negedge sysclk);
      exp_d = (i == 0) ? 8'h55 : 8'h00;
      chk($sformatf("b2b%0d_valid", i), a_valid, 1'b1);
      chk($sformatf("b2b%0d_data", i), a_rdata, exp_d);
    end
    req_valid = 1'b0;
    @(negedge sysclk);
    chk("b2b_idle", {a_valid, a_rdata}, 9'h000);
    repeat (4) @(negedge sysclk);

    // Write then read on the very next cycle
    do_write(8'h7F, 8'hA3);
    do_read(8'h7F, 8'hA3, 1'b0, 8'hA3, 1'b0);

    // Range boundary: 0xC8 is out of range only for DEPTH=200
    do_write(8'hC8, 8'hFF);
    do_read(8'hC8, 8'hFF, 1'b0, 8'h00, 1'b1);
    do_read(8'hC7, 8'h00, 1'b0, 8'h00, 1'b0);
    do_write(8'hC7, 8'h3C);
    do_read(8'hC7, 8'h3C, 1'b0, 8'h3C, 1'b0);

    // clear_req with reads in flight: drain, then full clear
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h7F;
    @(posedge sysclk); #1;
    @(negedge sysclk);
    chk("cl_a_rd1", a_valid && a_rdata == 8'hA3, 1'b1);
    @(posedge sysclk); #1;
    clear_req = 1'b1; req_write = 1'b1; req_addr = 8'h01; req_wdata = 8'h99;
    #1 chk("cl_ready", {a_ready, b_ready}, 2'b00);
    @(negedge sysclk);
    chk("cl_a_rd2", a_valid && a_rdata == 8'hA3, 1'b1);
    @(posedge sysclk); #1;
    clear_req = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    ba = 0; bb = 0; ra = 0; rb = 0; ga = 0; gb = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge sysclk);
      if (a_busy) ba++;
      if (b_busy) bb++;
      if (a_valid) begin ra++; if (a_rdata == 8'hA3 && !a_err) ga++; end
      if (b_valid) begin rb++; if (b_rdata == 8'hA3 && !b_err) gb++; end
      if (!a_busy && !b_busy) break;
    end
    chk("cl_a_busy_cycles", ba, 257);
    chk("cl_b_busy_cycles", bb, 203);
    chk("cl_a_late_rsp", ra, 0);
    chk("cl_b_rsp", rb, 2);
    chk("cl_b_rsp_good", gb, 2);
    chk("cl_ready_after", {a_ready, b_ready}, 2'b11);
    do_read(8'h7F, 8'h00, 1'b0, 8'h00, 1'b0);
    do_read(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

`ifdef DATA_MEM_PARITY_EN
    par_inject = 1'b1;
    do_write(8'h05, 8'h0F);
    par_inject = 1'b0;
    par_read(8'h05, 1'b1);
    do_write(8'h05, 8'h0F);
    par_read(8'h05, 1'b0);
`endif

    // Reset with reads in flight: no response may appear
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    @(posedge sysclk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    ra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge sysclk);
      if (a_valid || b_valid) ra++;
    end
    chk("mid_rst_rsp", ra, 0);
    chk_reset();
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    wait_init(256, 200);
    do_read(8'hC8, 8'h00, 1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
